// File: rtl/datapath_pkg.sv
// datapath_pkg: shared datapath sizing constants and the clog2 helper
package datapath_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int PC_REG_DEF   = 15;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_entry.sv
// regfile_entry: one architectural register with write enable and async active-low clear
module regfile_entry #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // hold the value, load on enable, clear on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with write-through bypass and pending-write scoreboard
module regfile_scoreboard
    import datapath_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int PC_REG   = PC_REG_DEF,
    parameter  int BYPASS   = 1,
    localparam int AW       = clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_addr,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy_vec
);
    localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);
    localparam logic [AW:0]   NR     = (AW+1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy, busy_nxt;
    logic                wr_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NR;
    endfunction

    // a legal index is a real storage register: in range and not the PC alias
    function automatic logic legal(input logic [AW-1:0] a);
        return a != PC_IDX && in_range(a);
    endfunction

    assign wr_ok    = wr_en && legal(wr_addr);
    assign busy_vec = busy;

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
        regfile_entry #(.W(DATA_W)) u_entry (
            .clk (clk),
            .rst (rst),
            .en  (wr_ok && wr_addr == AW'(n)),
            .d   (wr_data),
            .q   (regs[n])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = rd_addr[i*AW +: AW];
        assign hit = BYPASS != 0 && wr_ok && wr_addr == a;
        assign rd_data[i*DATA_W +: DATA_W] = a == PC_IDX ? pc_in :
                                             hit         ? wr_data :
                                             in_range(a) ? regs[a] : '0;
        assign rd_busy[i] = legal(a) && busy[a] && !hit;
    end

    // a write-back retiring the blocking write this cycle frees the destination immediately
    assign issue_ready = !flush && (!legal(issue_addr) || !busy[issue_addr] ||
                                    (wr_en && wr_addr == issue_addr));

    // scoreboard update: write-back clears, accepted issue sets (set wins), flush clears all
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) busy_nxt[wr_addr] = 1'b0;
        if (issue_valid && issue_ready && legal(issue_addr)) busy_nxt[issue_addr] = 1'b1;
        if (flush) busy_nxt = '0;
    end

    // scoreboard state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else busy <= busy_nxt;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;
    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] pc_in = 0;
    logic [7:0]  rd_addr = 0;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        wr_en = 0;
    logic [3:0]  wr_addr = 0;
    logic [31:0] wr_data = 0;
    logic        issue_valid = 0;
    logic [3:0]  issue_addr = 0;
    logic        issue_ready, issue_ready_nb;
    logic        flush = 0;
    logic [15:0] busy_vec, busy_vec_nb;

    int passed = 0;
    int fails = 0;
    int total = 0;

    logic [31:0] mreg [16];
    bit          mbusy [16];

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .flush(flush), .busy_vec(busy_vec)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .pc_in(pc_in), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready_nb),
        .flush(flush), .busy_vec(busy_vec_nb)
    );

    function automatic logic [31:0] exp_rd(int a, bit byp);
        if (a == 15) return pc_in;
        if (byp && wr_en && int'(wr_addr) == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic logic exp_rb(int a, bit byp);
        if (a == 15) return 1'b0;
        if (byp && wr_en && int'(wr_addr) == a) return 1'b0;
        return mbusy[a];
    endfunction

    function automatic logic exp_ready();
        int ia = int'(issue_addr);
        return !flush && (ia == 15 || !mbusy[ia] || (wr_en && int'(wr_addr) == ia));
    endfunction

    function automatic logic [15:0] exp_bv();
        logic [15:0] v;
        for (int n = 0; n < 16; n++) v[n] = mbusy[n];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 16; n++) begin
            mreg[n]  = 0;
            mbusy[n] = 0;
        end
    endtask

    task automatic model_edge();
        bit r;
        if (!rst) return;
        r = exp_ready();
        if (wr_en && wr_addr != 15) begin
            mreg[wr_addr]  = wr_data;
            mbusy[wr_addr] = 0;
        end
        if (issue_valid && r && issue_addr != 15) mbusy[issue_addr] = 1;
        if (flush) for (int n = 0; n < 16; n++) mbusy[n] = 0;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 2; i++) begin
            int a = int'(rd_addr[i*4 +: 4]);
            chk($sformatf("%s rd_data%0d", tag, i), 64'(rd_data[i*32 +: 32]), 64'(exp_rd(a, 1)));
            chk($sformatf("%s rd_data_nb%0d", tag, i), 64'(rd_data_nb[i*32 +: 32]), 64'(exp_rd(a, 0)));
            chk($sformatf("%s rd_busy%0d", tag, i), 64'(rd_busy[i]), 64'(exp_rb(a, 1)));
            chk($sformatf("%s rd_busy_nb%0d", tag, i), 64'(rd_busy_nb[i]), 64'(exp_rb(a, 0)));
        end
        chk({tag, " busy_vec"}, 64'(busy_vec), 64'(exp_bv()));
        chk({tag, " busy_vec_nb"}, 64'(busy_vec_nb), 64'(exp_bv()));
        chk({tag, " issue_ready"}, 64'(issue_ready), 64'(exp_ready()));
        chk({tag, " issue_ready_nb"}, 64'(issue_ready_nb), 64'(exp_ready()));
    endtask

    task automatic drive(bit we, int wa, logic [31:0] wd, bit iv, int ia, bit fl, int ra0, int ra1);
        wr_en       = we;
        wr_addr     = 4'(wa);
        wr_data     = wd;
        issue_valid = iv;
        issue_addr  = 4'(ia);
        flush       = fl;
        rd_addr     = {4'(ra1), 4'(ra0)};
    endtask

    task automatic step(string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        model_reset();
        pc_in = 32'h40;
        drive(0, 0, 0, 0, 0, 0, 15, 3);
        #2;
        check_all("por");
        @(posedge clk);
        #1;
        rst = 1;
        drive(1, 1, 32'h11, 0, 0, 0, 1, 2);
        step("pre_wr1");
        drive(1, 4, 32'h44, 1, 2, 0, 1, 4);
        step("pre_wr4");
        drive(0, 0, 0, 0, 0, 0, 15, 4);
        step("pre_chk");
        #3;
        rst = 0;
        model_reset();
        #1;
        check_all("midrun_reset");
        chk("midrun_reset pc_read", 64'(rd_data[31:0]), 64'h40);
        @(posedge clk);
        #1;
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        step("after_reset");
        drive(1, 1, 32'h19, 0, 0, 0, 1, 4);
        step("bypass_wr1");
        drive(0, 0, 0, 0, 0, 0, 1, 4);
        step("bypass_next");
        chk("r1_stored", 64'(rd_data_nb[31:0]), 64'h19);
        drive(0, 0, 0, 1, 4, 0, 4, 1);
        step("issue_r4");
        drive(0, 0, 0, 1, 4, 0, 4, 1);
        step("reissue_r4");
        chk("reissue_r4 blocked", 64'(issue_ready), 64'(0));
        drive(1, 4, 32'h1E, 1, 4, 0, 4, 2);
        step("wb_r4_and_issue");
        drive(0, 0, 0, 0, 4, 0, 4, 2);
        step("r4_after_set_wins");
        drive(1, 4, 32'h2A, 0, 4, 0, 4, 2);
        step("wb_r4_clear");
        drive(0, 0, 0, 0, 4, 0, 4, 2);
        step("r4_cleared");
        drive(1, 15, 32'hDEAD, 0, 0, 0, 15, 4);
        step("wr_pc");
        drive(0, 0, 0, 1, 15, 0, 15, 4);
        step("issue_pc");
        drive(0, 0, 0, 1, 2, 0, 15, 2);
        step("issue_r2");
        drive(0, 0, 0, 1, 3, 0, 2, 3);
        step("issue_r3");
        drive(0, 0, 0, 1, 7, 0, 7, 3);
        step("issue_r7");
        drive(0, 0, 0, 1, 5, 1, 7, 5);
        step("flush");
        drive(0, 0, 0, 0, 5, 0, 5, 7);
        step("after_flush");
        for (int k = 0; k < 400; k++) begin
            pc_in = $urandom;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15), $urandom_range(0, 15));
            step($sformatf("rand%0d", k));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with an integrated pending-write scoreboard. It is the next-generation replacement for the fixed 16×32, two-read-port register array inside the datapath. Width, register count and read-port count are configurable. The PC-mapped register index is retained. Two capabilities are new: same-cycle write-through bypass, and per-register busy tracking with an issue handshake, so the multi-cycle control unit can detect RAW hazards and stall on WAW hazards.

## Interface
- DATA_W, 32, data width of every register and port
- NUM_REGS, 16, number of architectural registers (≥2); AW = clog2(NUM_REGS)
- NUM_RD, 2, number of independent combinational read ports (1..4)
- PC_REG, 15, index that reads pc_in, ignores writes and is never busy
- BYPASS, 1, 1 = write data forwarded to reads of the same index in the same cycle
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_in  in  DATA_W  current PC, returned on reads of PC_REG
- rd_addr  in  NUM_RD*AW  packed read indices, port i at [i*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  port i's register has an outstanding pending write
- wr_en  in  1  write-back strobe
- wr_addr  in  AW  write-back index
- wr_data  in  DATA_W  write-back data
- issue_valid  in  1  control requests reservation of a destination register
- issue_addr  in  AW  destination to reserve
- issue_ready  out  1  reservation accepted this cycle
- flush  in  1  synchronous clear of all busy bits
- busy_vec  out  NUM_REGS  raw scoreboard state, bit n = register n pending

## Operation
- Storage: NUM_REGS×DATA_W array plus a NUM_REGS-bit busy vector.
- Write: on a clk edge with wr_en=1, reg[wr_addr] ← wr_data.
  - Ignored if wr_addr == PC_REG or wr_addr ≥ NUM_REGS.
  - A write clears busy[wr_addr] whether or not that bit was set.
- Read, port i, combinational, priority order:
  - rd_addr == PC_REG → pc_in.
  - Else if BYPASS and wr_en and wr_addr == rd_addr (legal index) → wr_data.
  - Else rd_addr ≥ NUM_REGS → 0.
  - Else → reg[rd_addr].
- rd_busy[i] = busy[rd_addr]. When BYPASS=1, it is masked to 0 while the same cycle's write targets rd_addr. It is always 0 for PC_REG and out-of-range indices.
- Issue handshake:
  - issue_ready = !flush && (issue_addr == PC_REG || issue_addr ≥ NUM_REGS || !busy[issue_addr] || (wr_en && wr_addr == issue_addr)).
  - Accept = issue_valid && issue_ready. On accept, busy[issue_addr] ← 1, unless the index is PC_REG or out of range; those are accepted with no effect.
  - issue_ready does not depend on issue_valid.
- Simultaneous events on the same index: an accepted issue and a write-back → busy ends at 1 (set wins), and the write data is still stored.
- flush=1: all busy bits ← 0 at the edge; issue_ready=0 that cycle. Writes still occur.

## Timing
- Reset (rst=0, asynchronous): every register ← 0, busy_vec ← 0. issue_ready follows its equation (1 unless flush). rd_data reflects the zeroed array, or pc_in for PC_REG.
- Write latency: stored at the edge and visible from the array next cycle. With BYPASS=1 it is also visible at zero latency.
- Busy set: visible on busy_vec/rd_busy the cycle after accept.
- Busy clear: visible the cycle after the write. With BYPASS=1, rd_busy is already masked in the write cycle.
- Deasserting rst mid-operation leaves all state zeroed. No pending write survives reset.
- No combinational path from issue_valid to any output.

## Structure
- Shared package (datapath_pkg): clog2 helper function, default PC_REG, DATA_W and NUM_REGS constants; the future control unit uses the same values.
- One sub-module, regfile_entry: a DATA_W-bit register with write enable and async active-low clear, instantiated NUM_REGS times via generate.
- Scoreboard, read muxes and issue logic live in the top level.

## Test plan
- Reset with rst=0 mid-run after writes → all rd_data 0, busy_vec 0, issue_ready 1; pc_in=0x40 read on index 15 → 0x40.
- Write 0x19 to r1 with rd_addr0=1 in the same cycle → rd_data0=0x19 that cycle (BYPASS=1); with BYPASS=0 → old value, then 0x19 next cycle.
- Issue r4 → busy_vec[4]=1 next cycle, rd_busy=1 on a port reading r4. Second issue of r4 → issue_ready=0. Write r4=0x1E → ready=1, busy cleared next cycle.
- Same cycle: write r4 plus issue r4 → r4=new data, busy[4]=1 afterward.
- Write 0xDEAD to r15 → ignored, reads still return pc_in. Issue r15 → accepted, busy_vec unchanged.
- Busy r2, r3, r7 then flush=1 with issue_valid on r5 → issue_ready=0, busy_vec=0 next cycle, r5 not reserved.
